// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch sequencer.
//
// Contents:
//   state_t        - 3-bit FSM state encoding (S_IDLE .. S_COMMIT)
//   BR_OPCODE      - default opcode value that identifies a branch
//   OPC_HI/OPC_LO  - bit bounds of the opcode field inside the instruction
package branch_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_PCY    = 3'd2,
        S_ADD    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    localparam logic [4:0] BR_OPCODE = 5'b10010;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;

endpackage

// File: rtl/branch_seq_sat_counter.sv
// Saturating up-counter used for the branch statistics.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   inc    in   increment request (ignored once the count is all-ones)
//   clr    in   clear; wins over a simultaneous increment
//   count  out  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_seq.sv
// Multi-cycle control sequencer for conditional branch instructions.
//
// Walks EVAL -> PCY -> ADD -> COMMIT, issuing the datapath strobes that load
// the condition flip-flop from register Ra, form PC + C in Z, and write Z
// back into PC only when the condition flip-flop reports the branch taken.
// With FAST_NOT_TAKEN set, a false condition seen in PCY skips the ADD step.
//
// Ports:
//   clk, reset_n       clock; synchronous reset, active-high despite its name
//   start              main controller requests a branch sequence
//   hold               stall: freezes state, strobes and counters
//   ir                 current instruction (opcode in ir[31:27])
//   con_out            condition flip-flop output, valid from PCY onward
//   cnt_clr            clears both statistics counters
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse in COMMIT
//   illegal            one-cycle pulse after a start with a non-branch opcode
//   gra .. pc_in       datapath strobes (Moore outputs of the state)
//   taken_cnt          saturating count of taken branches
//   ntaken_cnt         saturating count of not-taken branches
//
// Handshake: start is sampled only in IDLE while hold is low. done is high
// for exactly one non-held COMMIT cycle; a start presented in that same cycle
// is not seen, because the FSM is not yet back in IDLE.
module branch_seq #(
    parameter int         REG_SIZE       = 32,
    parameter logic [4:0] BR_OPCODE      = branch_seq_pkg::BR_OPCODE,
    parameter bit         FAST_NOT_TAKEN = 1'b0,
    parameter int         CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                hold,
    input  logic [REG_SIZE-1:0] ir,
    input  logic                con_out,
    input  logic                cnt_clr,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                gra,
    output logic                r_out,
    output logic                con_in,
    output logic                pc_out,
    output logic                y_in,
    output logic                c_out,
    output logic                alu_add,
    output logic                z_in,
    output logic                zlo_out,
    output logic                pc_in,
    output logic [CNT_W-1:0]    taken_cnt,
    output logic [CNT_W-1:0]    ntaken_cnt
);

    import branch_seq_pkg::*;

    state_t     state;
    state_t     state_nx;
    logic [4:0] opcode;
    logic       is_br;
    logic       illegal_q;
    logic       commit_live;
    logic       unused_ir;

    assign opcode    = ir[OPC_HI:OPC_LO];
    assign is_br     = (opcode == BR_OPCODE);
    // Only the opcode field steers this block; the rest of ir belongs to the datapath.
    assign unused_ir = ^ir;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= (state == S_IDLE) && start && !hold && !is_br;
        end
    end

    always_comb begin
        state_nx = state;
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        pc_out   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_add  = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        pc_in    = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && is_br) state_nx = S_EVAL;
            end
            S_EVAL: begin
                gra      = 1'b1;
                r_out    = 1'b1;
                con_in   = 1'b1;
                state_nx = S_PCY;
            end
            S_PCY: begin
                pc_out   = 1'b1;
                y_in     = 1'b1;
                state_nx = (FAST_NOT_TAKEN && !con_out) ? S_COMMIT : S_ADD;
            end
            S_ADD: begin
                c_out    = 1'b1;
                alu_add  = 1'b1;
                z_in     = 1'b1;
                state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                zlo_out  = con_out;
                pc_in    = con_out;
                // Suppressed while held so the pulse appears once, on release.
                done     = !hold;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (hold) state_nx = state;
    end

    assign busy        = (state != S_IDLE);
    assign illegal     = illegal_q;
    assign commit_live = (state == S_COMMIT) && !hold;

    // hold freezes the counters, including a pending clear.
    sat_counter #(.W(CNT_W)) u_taken (
        .clk   (clk),
        .rst   (reset_n),
        .inc   (commit_live && con_out),
        .clr   (cnt_clr && !hold),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ntaken (
        .clk   (clk),
        .rst   (reset_n),
        .inc   (commit_live && !con_out),
        .clr   (cnt_clr && !hold),
        .count (ntaken_cnt)
    );

endmodule

// File: tb/tb_branch_seq.sv
module tb_branch_seq;

    localparam logic [4:0] BR_OP = 5'b10010;
    localparam int K_IDLE   = 0;
    localparam int K_EVAL   = 1;
    localparam int K_PCY    = 2;
    localparam int K_ADD    = 3;
    localparam int K_COMMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        hold    = 1'b0;
    logic [31:0] ir      = '0;
    logic        con_out = 1'b0;
    logic        cnt_clr = 1'b0;

    // instance a: FAST_NOT_TAKEN=0, 16-bit counters
    logic busy_a, done_a, illegal_a, gra_a, r_out_a, con_in_a, pc_out_a, y_in_a;
    logic c_out_a, alu_add_a, z_in_a, zlo_out_a, pc_in_a;
    logic [15:0] taken_a, ntaken_a;
    // instance b: FAST_NOT_TAKEN=1, 4-bit counters (reachable saturation)
    logic busy_b, done_b, illegal_b, gra_b, r_out_b, con_in_b, pc_out_b, y_in_b;
    logic c_out_b, alu_add_b, z_in_b, zlo_out_b, pc_in_b;
    logic [3:0] taken_b, ntaken_b;

    branch_seq #(.REG_SIZE(32), .BR_OPCODE(5'b10010), .FAST_NOT_TAKEN(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold), .ir(ir),
        .con_out(con_out), .cnt_clr(cnt_clr), .busy(busy_a), .done(done_a),
        .illegal(illegal_a), .gra(gra_a), .r_out(r_out_a), .con_in(con_in_a),
        .pc_out(pc_out_a), .y_in(y_in_a), .c_out(c_out_a), .alu_add(alu_add_a),
        .z_in(z_in_a), .zlo_out(zlo_out_a), .pc_in(pc_in_a),
        .taken_cnt(taken_a), .ntaken_cnt(ntaken_a)
    );

    branch_seq #(.REG_SIZE(32), .BR_OPCODE(5'b10010), .FAST_NOT_TAKEN(1'b1), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold), .ir(ir),
        .con_out(con_out), .cnt_clr(cnt_clr), .busy(busy_b), .done(done_b),
        .illegal(illegal_b), .gra(gra_b), .r_out(r_out_b), .con_in(con_in_b),
        .pc_out(pc_out_b), .y_in(y_in_b), .c_out(c_out_b), .alu_add(alu_add_b),
        .z_in(z_in_b), .zlo_out(zlo_out_b), .pc_in(pc_in_b),
        .taken_cnt(taken_b), .ntaken_cnt(ntaken_b)
    );

    wire [12:0] obs_a = {busy_a, done_a, illegal_a, gra_a, r_out_a, con_in_a, pc_out_a,
                         y_in_a, c_out_a, alu_add_a, z_in_a, zlo_out_a, pc_in_a};
    wire [12:0] obs_b = {busy_b, done_b, illegal_b, gra_b, r_out_b, con_in_b, pc_out_b,
                         y_in_b, c_out_b, alu_add_b, z_in_b, zlo_out_b, pc_in_b};

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each instance keeps a queue of the steps still to perform; the front is
    // the current step, an empty queue means idle.
    int sq0[$];
    int sq1[$];
    int tk[2];
    int nt[2];
    bit ill[2];

    function automatic int cur(input int id);
        if (id == 0) return (sq0.size() != 0) ? sq0[0] : K_IDLE;
        return (sq1.size() != 0) ? sq1[0] : K_IDLE;
    endfunction

    function automatic bit fast_of(input int id);
        return id == 1;
    endfunction

    function automatic int cmax_of(input int id);
        return (id == 0) ? 65535 : 15;
    endfunction

    task automatic q_clear(input int id);
        if (id == 0) sq0.delete(); else sq1.delete();
    endtask

    task automatic q_load(input int id);
        if (id == 0) sq0 = '{K_EVAL, K_PCY, K_ADD, K_COMMIT};
        else         sq1 = '{K_EVAL, K_PCY, K_ADD, K_COMMIT};
    endtask

    task automatic q_skip_add(input int id);
        if (id == 0) sq0.delete(1); else sq1.delete(1);
    endtask

    task automatic q_pop(input int id);
        if (id == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
    endtask

    task automatic model_step(input int id);
        int s;
        s = cur(id);
        if (reset_n) begin
            q_clear(id);
            tk[id]  = 0;
            nt[id]  = 0;
            ill[id] = 1'b0;
        end else begin
            ill[id] = (s == K_IDLE) && start && !hold && (ir[31:27] != BR_OP);
            if (!hold) begin
                if (cnt_clr) begin
                    tk[id] = 0;
                    nt[id] = 0;
                end else if (s == K_COMMIT) begin
                    if (con_out) tk[id] = (tk[id] < cmax_of(id)) ? tk[id] + 1 : tk[id];
                    else         nt[id] = (nt[id] < cmax_of(id)) ? nt[id] + 1 : nt[id];
                end
                if (s == K_IDLE) begin
                    if (start && ir[31:27] == BR_OP) q_load(id);
                end else begin
                    if (s == K_PCY && fast_of(id) && !con_out) q_skip_add(id);
                    q_pop(id);
                end
            end
        end
    endtask

    // {busy, done, illegal, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in}
    function automatic logic [12:0] exp_obs(input int id);
        int s;
        logic [12:0] v;
        s = cur(id);
        v = '0;
        v[12] = (s != K_IDLE);
        v[11] = (s == K_COMMIT) && !hold;
        v[10] = ill[id];
        v[9]  = (s == K_EVAL);
        v[8]  = (s == K_EVAL);
        v[7]  = (s == K_EVAL);
        v[6]  = (s == K_PCY);
        v[5]  = (s == K_PCY);
        v[4]  = (s == K_ADD);
        v[3]  = (s == K_ADD);
        v[2]  = (s == K_ADD);
        v[1]  = (s == K_COMMIT) && con_out;
        v[0]  = (s == K_COMMIT) && con_out;
        return v;
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("obs_a", {19'b0, obs_a}, {19'b0, exp_obs(0)});
            chk("taken_a", {16'b0, taken_a}, tk[0]);
            chk("ntaken_a", {16'b0, ntaken_a}, nt[0]);
            chk("obs_b", {19'b0, obs_b}, {19'b0, exp_obs(1)});
            chk("taken_b", {28'b0, taken_b}, tk[1]);
            chk("ntaken_b", {28'b0, ntaken_b}, nt[1]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    // Issues one branch and watches 12 cycles; latencies are counted from the
    // start cycle, hold covers cycles [2, 2+hc), cnt_clr is raised in clr_at.
    task automatic run_branch(input bit c, input int hc, input int clr_at,
                              output int la, output int lb,
                              output logic [1:0] pa, output logic [1:0] pb,
                              output int nda, output int ndb);
        la = 0; lb = 0; pa = '0; pb = '0; nda = 0; ndb = 0;
        @(negedge clk);
        start   = 1'b1;
        ir      = {BR_OP, 27'($urandom)};
        con_out = c;
        hold    = 1'b0;
        cnt_clr = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            hold    = (cyc >= 2) && (cyc < 2 + hc);
            cnt_clr = (cyc == clr_at);
            #2;
            if (done_a) begin
                nda++;
                if (la == 0) begin la = cyc; pa = {pc_in_a, zlo_out_a}; end
            end
            if (done_b) begin
                ndb++;
                if (lb == 0) begin lb = cyc; pb = {pc_in_b, zlo_out_b}; end
            end
        end
        cnt_clr = 1'b0;
        hold    = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int la, lb, nda, ndb;
        logic [1:0] pa, pb;
        bit saw_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        chk_en  = 1'b1;
        #2;
        chk("reset_obs_a", {19'b0, obs_a}, 32'h0);
        chk("reset_taken_a", {16'b0, taken_a}, 32'h0);

        // taken branch: 4-cycle latency on both, PC written
        run_branch(1'b1, 0, 0, la, lb, pa, pb, nda, ndb);
        chk("taken_lat_a", la, 4);
        chk("taken_lat_b", lb, 4);
        chk("taken_pc_zlo_a", {30'b0, pa}, 32'h3);
        chk("taken_one_done_a", nda, 1);
        chk("taken_cnt_a", {16'b0, taken_a}, 32'h1);
        chk("taken_cnt_b", {28'b0, taken_b}, 32'h1);

        // not taken: ADD kept on a, skipped on b
        run_branch(1'b0, 0, 0, la, lb, pa, pb, nda, ndb);
        chk("ntaken_lat_a", la, 4);
        chk("ntaken_lat_b", lb, 3);
        chk("ntaken_pc_zlo_a", {30'b0, pa}, 32'h0);
        chk("ntaken_pc_zlo_b", {30'b0, pb}, 32'h0);
        chk("ntaken_cnt_a", {16'b0, ntaken_a}, 32'h1);

        // illegal opcode: one-cycle pulse, no sequence
        @(negedge clk);
        start = 1'b1;
        ir    = {5'b00011, 27'($urandom)};
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("illegal_pulse_a", {31'b0, illegal_a}, 32'h1);
        chk("illegal_busy_a", {31'b0, busy_a}, 32'h0);
        @(negedge clk);
        #2;
        chk("illegal_clear_a", {31'b0, illegal_a}, 32'h0);
        chk("illegal_cnt_a", {16'b0, taken_a}, 32'h1);

        // hold for 3 cycles in PCY stretches latency to 7
        run_branch(1'b1, 3, 0, la, lb, pa, pb, nda, ndb);
        chk("hold_lat_a", la, 7);
        chk("hold_one_done_a", nda, 1);
        chk("hold_one_done_b", ndb, 1);
        chk("hold_taken_a", {16'b0, taken_a}, 32'h2);

        // reset during ADD
        @(negedge clk);
        start   = 1'b1;
        ir      = {BR_OP, 27'($urandom)};
        con_out = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("rst_mid_obs_a", {19'b0, obs_a}, 32'h0);
        chk("rst_mid_taken_a", {16'b0, taken_a}, 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            if (done_a || done_b) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", {31'b0, saw_done}, 32'h0);

        // saturation of the 4-bit counter on b
        for (int i = 0; i < 17; i++) run_branch(1'b1, 0, 0, la, lb, pa, pb, nda, ndb);
        chk("sat_taken_b", {28'b0, taken_b}, 32'hF);
        chk("sat_taken_a", {16'b0, taken_a}, 32'd17);

        // clear in the COMMIT cycle wins over the increment
        run_branch(1'b1, 0, 4, la, lb, pa, pb, nda, ndb);
        chk("clr_taken_a", {16'b0, taken_a}, 32'h0);
        chk("clr_taken_b", {28'b0, taken_b}, 32'h0);

        // randomized phase, checked by the compare process every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            ir      = {($urandom_range(0, 1) == 0) ? BR_OP : 5'($urandom), 27'($urandom)};
            hold    = ($urandom_range(0, 4) == 0);
            con_out = 1'($urandom);
            cnt_clr = ($urandom_range(0, 29) == 0);
            reset_n = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Multi-cycle control sequencer for conditional branch instructions.
- Drives the strobes that load the condition flip-flop from the register selected by Ra and form PC + C.
- Writes the result to PC only if the flip-flop reports the condition met.
- Sits beside the main control unit, which hands over each branch via a start/done handshake. Also keeps saturating taken/not-taken counters for debug.

Parameters:
- REG_SIZE, 32, instruction register width
- BR_OPCODE, 5'b10010, value of ir[31:27] that identifies a branch
- FAST_NOT_TAKEN, 0, when 1 skip the ADD step if the condition is false
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-high (asserted = 1)
- start  in  1  main controller requests a branch sequence
- hold  in  1  freeze the FSM and all strobes in the current state (memory/bus stall)
- ir  in  REG_SIZE  current instruction
- con_out  in  1  condition flip-flop output
- cnt_clr  in  1  clear both statistics counters
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse: start issued with a non-branch opcode
- gra  out  1  select the Ra field for register-out
- r_out  out  1  register file drives the bus
- con_in  out  1  load enable for the condition flip-flop
- pc_out  out  1  PC drives the bus
- y_in  out  1  load Y
- c_out  out  1  sign-extended C drives the bus
- alu_add  out  1  ALU op = ADD
- z_in  out  1  load Z
- zlo_out  out  1  Z low word drives the bus
- pc_in  out  1  load PC
- taken_cnt  out  CNT_W  branches taken
- ntaken_cnt  out  CNT_W  branches not taken

Behaviour:
- Reset (reset_n=1 at a clock edge): state=IDLE; all outputs 0; both counters 0. Reset mid-sequence aborts with no done and no pc_in.
- Strobes are Moore outputs of the state. Only one bus driver is asserted per state.
- IDLE:
  - start=1 and ir[31:27]==BR_OPCODE -> EVAL.
  - start=1 with any other opcode -> stay in IDLE; illegal=1 for the next cycle.
  - start is ignored while busy.
- EVAL: gra, r_out, con_in=1. The flip-flop captures at the end of this cycle. -> PCY.
- PCY: pc_out, y_in=1.
  - con_out is valid from this state on.
  - If FAST_NOT_TAKEN=1 and con_out=0 -> COMMIT; otherwise -> ADD.
- ADD: c_out, alu_add, z_in=1. -> COMMIT.
- COMMIT: zlo_out=1 only if con_out=1; pc_in=con_out; done=1. -> IDLE.
  - Taken: PC loads PC+C.
  - Not taken: PC unchanged.
- busy=1 in every state except IDLE.
- Latency from start to done: 4 cycles (EVAL, PCY, ADD, COMMIT). With fast not-taken the not-taken path is 3 cycles.
- hold=1: state, strobes and counters are frozen. done, illegal and counter increments are not repeated while held.
  - hold has priority over start in IDLE.
  - hold has no effect on reset.
- Counters:
  - In COMMIT (not held), increment taken_cnt if con_out=1, else ntaken_cnt.
  - Counters saturate at all-ones; no wrap.
  - cnt_clr has priority over a simultaneous increment.
- start asserted in the same cycle as done: ignored. A new start is accepted from the next IDLE cycle. Back-to-back branches are therefore spaced at least 5 cycles apart.

Decomposition:
- Shared package holds:
  - state encoding constants (S_IDLE, S_EVAL, S_PCY, S_ADD, S_COMMIT; 3-bit);
  - BR_OPCODE;
  - the opcode field bounds (31:27).
- One sub-module, sat_counter (width CNT_W, inputs inc and clr), instantiated twice.
- Strobe decode stays inline.

Test Plan:
- Reset, then branch with con_out=1 from EVAL onward: strobes EVAL→PCY→ADD→COMMIT in consecutive cycles; pc_in=1 and zlo_out=1 in COMMIT; done pulses at cycle 4; taken_cnt=1.
- Same with con_out=0 and FAST_NOT_TAKEN=0: ADD still visited; pc_in=0 and zlo_out=0 in COMMIT; ntaken_cnt=1. With FAST_NOT_TAKEN=1: ADD skipped, done at cycle 3.
- start with ir[31:27]=5'b00011: no state change; illegal=1 for one cycle; busy stays 0; counters unchanged.
- hold=1 for 3 cycles while in PCY: outputs frozen (pc_out=1, y_in=1), no double done, total latency 7 cycles.
- reset_n=1 during ADD: next cycle IDLE, all strobes 0, no done, counters 0.
- Force taken_cnt to 16'hFFFF via repeated taken branches: stays 16'hFFFF. Assert cnt_clr in a COMMIT cycle: counter reads 0 afterward.
